// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU-side memory port arbiter.
// Holds FSM state encodings, access sizes, kseg mapping and arbitration mode selectors.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_BUSY = 2'd1,
      STATE_DONE = 2'd2
   } state_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // kseg0/kseg1 (top bits 10x) alias physical memory with the top three bits cleared
   localparam logic [1:0] KSEG_MATCH = 2'b10;
   localparam int         KSEG_CLR_W = 3;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational requester selector: fixed priority (index 0 first) or round robin
// starting one past the last granted index.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int N    = 2,
   parameter int MODE = ARB_RR,
   parameter int IW   = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   always_comb begin
      int start;
      int p;
      // NOTE: every output gets a default before the scan so no path leaves a latch.
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      start   = (MODE == ARB_RR) ? int'(last_i) + 1 : 0;
      if (start >= N) start = 0;
      for (int i = 0; i < N; i++) begin
         p = start + i;
         if (p >= N) p = p - N;
         if (!valid_o && req_i[p]) begin
            valid_o    = 1'b1;
            grant_o[p] = 1'b1;
            idx_o      = IW'(p);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multiplexes N sram-like CPU requesters onto the single mem_* port of axi_interface,
// with registered downstream request, one-cycle ready pulse and optional kseg mapping.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ARB_MODE  = 1,
   parameter int MAP_KSEG  = 1,
   localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS-1:0]        req_access,
   input  logic [NUM_PORTS-1:0]        req_write,
   input  logic [2*NUM_PORTS-1:0]      req_size,
   input  logic [4*NUM_PORTS-1:0]      req_sel,
   input  logic [ADDR_W*NUM_PORTS-1:0] req_addr,
   input  logic [DATA_W*NUM_PORTS-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]        req_ready,
   output logic [DATA_W-1:0]           req_rdata,
   input  logic                        flush,
   output logic                        mem_access,
   output logic                        mem_write,
   output logic [1:0]                  mem_size,
   output logic [3:0]                  mem_sel,
   output logic [ADDR_W-1:0]           mem_a,
   output logic [DATA_W-1:0]           mem_st_data,
   output logic                        mem_flush,
   input  logic                        mem_ready,
   input  logic [DATA_W-1:0]           mem_data,
   output logic [IDX_W-1:0]            grant_id
);

   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);

   state_e                 state_q;
   logic [IDX_W-1:0]       last_q;
   logic [IDX_W-1:0]       grant_id_q;
   logic [NUM_PORTS-1:0]   grant_oh_q;
   logic [NUM_PORTS-1:0]   req_ready_q;
   logic [DATA_W-1:0]      req_rdata_q;
   logic                   mem_access_q;
   logic                   mem_write_q;
   logic [1:0]             mem_size_q;
   logic [3:0]             mem_sel_q;
   logic [ADDR_W-1:0]      mem_a_q;
   logic [DATA_W-1:0]      mem_st_data_q;

   logic [NUM_PORTS-1:0]   win_oh_d;
   logic [IDX_W-1:0]       win_idx_d;
   logic                   win_valid_d;
   logic [ADDR_W-1:0]      win_addr_d;
   logic [ADDR_W-1:0]      mapped_addr_d;

   rr_picker #(
      .N    (NUM_PORTS),
      .MODE (ARB_MODE),
      .IW   (IDX_W)
   ) u_picker (
      .req_i   (req_access),
      .last_i  (last_q),
      .grant_o (win_oh_d),
      .idx_o   (win_idx_d),
      .valid_o (win_valid_d)
   );

   assign win_addr_d = req_addr[int'(win_idx_d)*ADDR_W +: ADDR_W];

   always_comb begin
      mapped_addr_d = win_addr_d;
      if (MAP_KSEG == 1 && win_addr_d[ADDR_W-1 -: 2] == KSEG_MATCH)
         mapped_addr_d[ADDR_W-1 -: KSEG_CLR_W] = '0;
   end

   // Flush wins over a coincident mem_ready: the cancelled access never reports completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= STATE_IDLE;
         last_q        <= LAST_RST;
         grant_id_q    <= '0;
         grant_oh_q    <= '0;
         req_ready_q   <= '0;
         req_rdata_q   <= '0;
         mem_access_q  <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_size_q    <= '0;
         mem_sel_q     <= '0;
         mem_a_q       <= '0;
         mem_st_data_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
         case (state_q)
            STATE_IDLE: begin
               if (!flush && win_valid_d) begin
                  mem_access_q  <= 1'b1;
                  mem_write_q   <= req_write[win_idx_d];
                  mem_size_q    <= req_size[int'(win_idx_d)*2 +: 2];
                  mem_sel_q     <= req_sel[int'(win_idx_d)*4 +: 4];
                  mem_a_q       <= mapped_addr_d;
                  mem_st_data_q <= req_wdata[int'(win_idx_d)*DATA_W +: DATA_W];
                  grant_id_q    <= win_idx_d;
                  grant_oh_q    <= win_oh_d;
                  last_q        <= win_idx_d;
                  state_q       <= STATE_BUSY;
               end
            end
            STATE_BUSY: begin
               if (flush) begin
                  mem_access_q <= 1'b0;
                  state_q      <= STATE_IDLE;
               end else if (mem_ready) begin
                  req_rdata_q  <= mem_data;
                  req_ready_q  <= grant_oh_q;
                  mem_access_q <= 1'b0;
                  state_q      <= STATE_DONE;
               end
            end
            STATE_DONE: begin
               req_ready_q <= '0;
               state_q     <= STATE_IDLE;
            end
            default: state_q <= STATE_IDLE;
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign req_rdata   = req_rdata_q;
   assign mem_access  = mem_access_q;
   assign mem_write   = mem_write_q;
   assign mem_size    = mem_size_q;
   assign mem_sel     = mem_sel_q;
   assign mem_a       = mem_a_q;
   assign mem_st_data = mem_st_data_q;
   assign mem_flush   = flush;
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin/kseg instance and a fixed-priority/unmapped
// instance share one stimulus stream and are checked against a queue-free arbitration model.
module tb_mem_port_arbiter;

   localparam int NP = 2;

   logic          clk;
   logic          rst;
   logic [NP-1:0] req_access;
   logic [NP-1:0] req_write;
   logic [2*NP-1:0]  req_size;
   logic [4*NP-1:0]  req_sel;
   logic [32*NP-1:0] req_addr;
   logic [32*NP-1:0] req_wdata;
   logic          flush;
   logic          mem_ready;
   logic [31:0]   mem_data;

   logic [NP-1:0] r_req_ready, f_req_ready;
   logic [31:0]   r_req_rdata, f_req_rdata;
   logic          r_mem_access, f_mem_access;
   logic          r_mem_write, f_mem_write;
   logic [1:0]    r_mem_size, f_mem_size;
   logic [3:0]    r_mem_sel, f_mem_sel;
   logic [31:0]   r_mem_a, f_mem_a;
   logic [31:0]   r_mem_st_data, f_mem_st_data;
   logic          r_mem_flush, f_mem_flush;
   logic [0:0]    r_grant_id, f_grant_id;

   int n_asserts = 0;
   int n_fail    = 0;
   int last_m    = NP - 1;

   mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .MAP_KSEG(1)) u_rr (
      .clk(clk), .rst(rst), .req_access(req_access), .req_write(req_write), .req_size(req_size),
      .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(r_req_ready),
      .req_rdata(r_req_rdata), .flush(flush), .mem_access(r_mem_access), .mem_write(r_mem_write),
      .mem_size(r_mem_size), .mem_sel(r_mem_sel), .mem_a(r_mem_a), .mem_st_data(r_mem_st_data),
      .mem_flush(r_mem_flush), .mem_ready(mem_ready), .mem_data(mem_data), .grant_id(r_grant_id)
   );

   mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .MAP_KSEG(0)) u_fix (
      .clk(clk), .rst(rst), .req_access(req_access), .req_write(req_write), .req_size(req_size),
      .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(f_req_ready),
      .req_rdata(f_req_rdata), .flush(flush), .mem_access(f_mem_access), .mem_write(f_mem_write),
      .mem_size(f_mem_size), .mem_sel(f_mem_sel), .mem_a(f_mem_a), .mem_st_data(f_mem_st_data),
      .mem_flush(f_mem_flush), .mem_ready(mem_ready), .mem_data(mem_data), .grant_id(f_grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Winner: first requesting port scanning from (last+1) for round robin, from 0 for fixed.
   function automatic int pick(input logic [NP-1:0] req, input int last, input bit rr);
      int start;
      start = rr ? (last + 1) % NP : 0;
      for (int i = 0; i < NP; i++)
         if (req[(start + i) % NP]) return (start + i) % NP;
      return -1;
   endfunction

   function automatic logic [31:0] kmap(input logic [31:0] a, input bit en);
      if (en && (a >> 30) == 32'd2) return a & 32'h1fff_ffff;
      return a;
   endfunction

   task automatic randomize_ports();
      for (int p = 0; p < NP; p++) begin
         req_write[p]          = 1'($urandom_range(0, 1));
         req_size[p*2 +: 2]    = 2'($urandom_range(0, 2));
         req_sel[p*4 +: 4]     = 4'($urandom);
         req_addr[p*32 +: 32]  = $urandom;
         req_wdata[p*32 +: 32] = $urandom;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_r_access"}, 64'(r_mem_access), 64'(0));
      check({tag, "_f_access"}, 64'(f_mem_access), 64'(0));
      check({tag, "_r_ready"},  64'(r_req_ready),  64'(0));
      check({tag, "_f_ready"},  64'(f_req_ready),  64'(0));
   endtask

   // One full transaction on both instances; requests must be set and both DUTs idle.
   task automatic run_txn(input int lat, input bit do_flush, input bit keep_req, input logic [31:0] rdata);
      int rg, fg;
      logic [31:0] r_ea, f_ea;
      rg   = pick(req_access, last_m, 1'b1);
      fg   = pick(req_access, 0, 1'b0);
      r_ea = kmap(req_addr[rg*32 +: 32], 1'b1);
      f_ea = kmap(req_addr[fg*32 +: 32], 1'b0);
      step();
      check("rr_access",  64'(r_mem_access),  64'(1));
      check("rr_grant",   64'(r_grant_id),    64'(rg));
      check("rr_addr",    64'(r_mem_a),       64'(r_ea));
      check("rr_write",   64'(r_mem_write),   64'(req_write[rg]));
      check("rr_size",    64'(r_mem_size),    64'(req_size[rg*2 +: 2]));
      check("rr_sel",     64'(r_mem_sel),     64'(req_sel[rg*4 +: 4]));
      check("rr_wdata",   64'(r_mem_st_data), 64'(req_wdata[rg*32 +: 32]));
      check("fix_access", 64'(f_mem_access),  64'(1));
      check("fix_grant",  64'(f_grant_id),    64'(fg));
      check("fix_addr",   64'(f_mem_a),       64'(f_ea));
      check("fix_wdata",  64'(f_mem_st_data), 64'(req_wdata[fg*32 +: 32]));
      last_m = rg;
      randomize_ports();
      for (int i = 0; i < lat; i++) begin
         step();
         check("busy_hold_addr",  64'(r_mem_a),      64'(r_ea));
         check("busy_hold_acc",   64'(r_mem_access), 64'(1));
         check("busy_no_ready",   64'(r_req_ready | f_req_ready), 64'(0));
      end
      if (do_flush) begin
         flush = 1'b1;
         #1;
         check("flush_pass_r", 64'(r_mem_flush), 64'(1));
         check("flush_pass_f", 64'(f_mem_flush), 64'(1));
         step();
         flush = 1'b0;
         check_idle_outputs("flush");
         req_access = '0;
         mem_data   = $urandom;
         mem_ready  = 1'b1;
         step();
         mem_ready = 1'b0;
         check_idle_outputs("late_ready");
      end else begin
         mem_data  = rdata;
         mem_ready = 1'b1;
         step();
         mem_ready = 1'b0;
         check("rr_ready",   64'(r_req_ready),  64'(1 << rg));
         check("rr_rdata",   64'(r_req_rdata),  64'(rdata));
         check("rr_acc_off", 64'(r_mem_access), 64'(0));
         check("fix_ready",  64'(f_req_ready),  64'(1 << fg));
         check("fix_rdata",  64'(f_req_rdata),  64'(rdata));
         if (!keep_req) req_access = '0;
         step();
         check_idle_outputs("done");
      end
   endtask

   initial begin
      rst        = 1'b1;
      req_access = '0;
      req_write  = '0;
      req_size   = '0;
      req_sel    = '0;
      req_addr   = '0;
      req_wdata  = '0;
      flush      = 1'b0;
      mem_ready  = 1'b0;
      mem_data   = '0;
      step();
      step();
      check_idle_outputs("reset");
      check("reset_grant",  64'(r_grant_id),    64'(0));
      check("reset_addr",   64'(r_mem_a),       64'(0));
      check("reset_wdata",  64'(r_mem_st_data), 64'(0));
      check("reset_rdata",  64'(r_req_rdata),   64'(0));
      check("reset_misc",   64'({r_mem_write, r_mem_size, r_mem_sel}), 64'(0));
      rst = 1'b0;
      step();

      // Port 0 load from kseg1 boot vector
      req_addr[31:0]  = 32'h9fc0_0000;
      req_write[0]    = 1'b0;
      req_size[1:0]   = 2'd2;
      req_sel[3:0]    = 4'hf;
      req_access      = 2'b01;
      run_txn(2, 1'b0, 1'b0, 32'h1234_5678);

      // Both ports requesting continuously: round robin alternates, fixed always picks 0
      randomize_ports();
      req_access = 2'b11;
      for (int k = 0; k < 4; k++) run_txn(k % 3, 1'b0, 1'b1, $urandom);
      req_access = 2'b10;
      run_txn(1, 1'b0, 1'b0, $urandom);

      // Port 1 store into kseg1
      req_write[1]      = 1'b1;
      req_size[3:2]     = 2'd2;
      req_sel[7:4]      = 4'b0011;
      req_addr[63:32]   = 32'hbfaf_8000;
      req_wdata[63:32]  = 32'hdead_beef;
      req_access        = 2'b10;
      run_txn(0, 1'b0, 1'b0, $urandom);

      // Flush on the second busy cycle, then a stray mem_ready
      randomize_ports();
      req_access = 2'b11;
      run_txn(1, 1'b1, 1'b0, 32'h0);

      for (int it = 0; it < 40; it++) begin
         randomize_ports();
         req_access = 2'($urandom);
         if (req_access == '0) begin
            step();
            check_idle_outputs("no_req");
         end else begin
            run_txn($urandom_range(0, 3), ($urandom_range(0, 5) == 0), 1'b0, $urandom);
         end
      end

      // Asynchronous reset while busy
      randomize_ports();
      req_access = 2'b11;
      step();
      step();
      rst = 1'b1;
      #1;
      check_idle_outputs("async_rst");
      check("async_rst_grant", 64'(r_grant_id), 64'(0));
      #2;
      rst    = 1'b0;
      last_m = NP - 1;
      run_txn(1, 1'b0, 1'b0, $urandom);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-requester arbiter that multiplexes CPU-side sram-like memory requests onto the single mem_* port of axi_interface.
- Requesters are instruction fetch, load/store, and future uncached/DMA ports.
- Generalises the fixed inst/data select with a configurable port count, fixed or round-robin priority, and a registered per-port ready/rdata return.
- Also provides optional kseg address mapping and flush cancellation.

Parameters:
- NUM_PORTS, 2, number of requesters (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ARB_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round robin
- MAP_KSEG, 1, 1 = physical mapping applied to the granted address: addr[31:30]==2'b10 clears addr[31:29]

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_access  in  NUM_PORTS  per-port request strobe, held until that port's req_ready
- req_write  in  NUM_PORTS  per-port 1 = store, 0 = load
- req_size  in  2*NUM_PORTS  per-port size (0 = byte, 1 = half, 2 = word)
- req_sel  in  4*NUM_PORTS  per-port byte strobe
- req_addr  in  ADDR_W*NUM_PORTS  per-port address
- req_wdata  in  DATA_W*NUM_PORTS  per-port store data
- req_ready  out  NUM_PORTS  one-cycle completion pulse to the granted port
- req_rdata  out  DATA_W  registered read data, valid when any req_ready bit is high
- flush  in  1  cancel in-flight and pending requests (exception)
- mem_access  out  1  downstream request
- mem_write  out  1  downstream write
- mem_size  out  2  downstream size
- mem_sel  out  4  downstream byte strobe
- mem_a  out  ADDR_W  downstream (mapped) address
- mem_st_data  out  DATA_W  downstream store data
- mem_flush  out  1  flush, passed combinationally to axi_interface
- mem_ready  in  1  downstream completion
- mem_data  in  DATA_W  downstream read data
- grant_id  out  clog2(NUM_PORTS) (minimum 1)  currently or last granted port, for debug

Behaviour:
- Reset values:
  - state = IDLE.
  - All mem_* outputs 0; req_ready 0; req_rdata 0; grant_id 0.
  - Round-robin pointer last = NUM_PORTS-1, so port 0 is served first.
- FSM is IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - If flush = 0 and |req_access, the winner g is chosen.
  - The winner's write/size/sel/mapped addr/wdata are latched into the mem_* output registers.
  - mem_access is set to 1 and grant_id to g; next state is BUSY.
  - The request is visible downstream one cycle after first sampling.
- Winner selection:
  - ARB_MODE = 0: lowest asserted index.
  - ARB_MODE = 1: first asserted index scanning from last+1 modulo NUM_PORTS. last is updated to g on grant.
- BUSY:
  - Outputs stay stable.
  - On mem_ready = 1: req_rdata <= mem_data, req_ready[g] <= 1, mem_access <= 0, next state DONE.
- DONE:
  - req_ready[g] is high for exactly this one cycle; it clears when leaving DONE.
  - Requests are not sampled in DONE, so the requester has one cycle to drop or change its request. Minimum back-to-back spacing is therefore 3 cycles.
  - Next state is IDLE.
- flush:
  - In BUSY: mem_access <= 0, no req_ready is issued, next state IDLE, and the round-robin pointer still advances.
  - In IDLE: no grant is made.
  - In DONE: the ready pulse already issued stands.
  - mem_flush = flush, combinational.
- mem_ready while not BUSY is ignored.
- Port changes after grant are ignored: latched values are used until completion.
- Mapping is applied only when MAP_KSEG = 1; otherwise the address passes unchanged.
- NUM_PORTS = 1: arbitration degenerates and grant_id stays 0.
- Reset asserted mid-transaction returns all state and outputs to reset values immediately (asynchronous).

Decomposition:
- Shared package mem_arb_pkg holds:
  - STATE_IDLE/BUSY/DONE encodings
  - SIZE_BYTE/HALF/WORD constants
  - KSEG mapping constants
  - ARB_FIXED/ARB_RR constants
- One sub-module, rr_picker: combinational priority/round-robin selector taking the request vector and last pointer, returning a one-hot grant and an index.

Test Plan:
- NUM_PORTS=2, RR: port0 load at 0x9fc00000, mem_ready after 3 cycles with mem_data=0x12345678 -> mem_a=0x1fc00000, mem_write=0; req_ready[0] pulses once 1 cycle after mem_ready; req_rdata=0x12345678.
- Both ports request continuously, RR mode -> grants alternate 0,1,0,1 (grant_id); each completion separated by ≥3 cycles; no port granted twice in a row.
- Same stimulus with ARB_MODE=0 -> port 0 is always granted while it requests; port 1 is served only after port0 drops req_access.
- Port1 store, addr 0xbfaf8000, sel=4'b0011, wdata=0xdeadbeef -> mem_write=1, mem_sel=0011, mem_a=0x1faf8000, mem_st_data=0xdeadbeef; req_ready[1] pulses after mem_ready.
- Flush in the 2nd BUSY cycle -> mem_access falls the next cycle, no req_ready pulse, state IDLE; a later mem_ready=1 is ignored.
- rst asserted while BUSY -> mem_access=0 and req_ready=0 immediately (asynchronous); after release, first grant goes to port 0.
